// File: rtl/diff_core_pkg.sv
// Shared PE-core types and constants: PE state codes, weight-slot select,
// FIFO depth, and the per-PE sequencer configuration record.
package diff_core_pkg;

    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned PE_SEQ_ROW_W = 10;
    localparam int unsigned PASSES_3x3   = 1;
    localparam int unsigned PASSES_5x5   = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ONE   = 3'd1,
        TWO   = 3'd2,
        THREE = 3'd3,
        FOUR  = 3'd4,
        FIVE  = 3'd5,
        SIX   = 3'd6
    } PE_state_t;

    typedef enum logic [2:0] {
        A_MODE = 3'd0,
        B_MODE = 3'd1,
        C_MODE = 3'd2,
        D_MODE = 3'd3,
        E_MODE = 3'd4
    } PE_weight_mode_t;

    typedef struct packed {
        logic                    kernel_mode;
        logic                    bit_mode;
        logic [PE_SEQ_ROW_W-1:0] out_rows;
    } pe_seq_cfg_t;

    function automatic logic is_pass_state(input PE_state_t s);
        return (s == TWO) || (s == THREE) || (s == FOUR) || (s == FIVE);
    endfunction

    // Pass index counts from TWO; the last pass depends on the kernel size.
    function automatic logic is_last_pass(input PE_state_t s, input logic kernel_mode);
        logic [2:0] idx;
        logic       last;
        idx = 3'(s) - 3'(TWO);
        if (kernel_mode) begin
            last = (idx == 3'(PASSES_5x5 - 1));
        end else begin
            last = (idx == 3'(PASSES_3x3 - 1));
        end
        return last;
    endfunction

    function automatic PE_weight_mode_t pass_wt_mode(input PE_state_t s, input logic kernel_mode);
        PE_weight_mode_t m;
        case (s)
            TWO:     m = kernel_mode ? A_MODE : E_MODE;
            THREE:   m = B_MODE;
            FOUR:    m = C_MODE;
            FIVE:    m = D_MODE;
            default: m = A_MODE;
        endcase
        return m;
    endfunction

    function automatic PE_state_t next_pass_state(input PE_state_t s);
        PE_state_t n;
        case (s)
            TWO:     n = THREE;
            THREE:   n = FOUR;
            FOUR:    n = FIVE;
            default: n = SIX;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pe_psum_credit.sv
// Credit counter for the PE psum output FIFO: one credit per free FIFO slot.
// A pop with all credits already returned is a consumer error and is dropped.
module pe_psum_credit
    import diff_core_pkg::*;
#(
    parameter int unsigned CREDITS = FIFO_DEPTH,
    localparam int unsigned CNT_W  = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    output logic [CNT_W-1:0] credits,
    output logic             has_credit
);

    localparam logic [CNT_W-1:0] MAX_CREDITS = CNT_W'(CREDITS);

    logic [CNT_W-1:0] credits_q;
    logic [CNT_W-1:0] credits_d;

    always_comb begin
        credits_d = credits_q;
        case ({push, pop})
            2'b10: if (credits_q != '0) credits_d = credits_q - 1'b1;
            2'b01: if (credits_q != MAX_CREDITS) credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits_q <= MAX_CREDITS;
        end else begin
            credits_q <= credits_d;
        end
    end

    assign credits    = credits_q;
    assign has_credit = (credits_q != '0);

endmodule

// File: rtl/pe_seq_ctrl.sv
// Per-PE sequencer: walks one PE through the weight passes of each output row
// and gates psum pushes on FIFO credits. PE_SEQ_PERF_CNT_EN adds stall_cycles.
module pe_seq_ctrl
    import diff_core_pkg::*;
#(
    parameter int unsigned ROW_W   = PE_SEQ_ROW_W,
    parameter int unsigned CREDITS = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             kernel_mode,
    input  logic             bit_mode,
    input  logic [ROW_W-1:0] out_rows,
    output logic             busy,
    output logic             done,
    output PE_state_t        state,
    output PE_weight_mode_t  wt_mode,
    input  logic             fm_valid,
    output logic             fm_ready,
    output logic             mac_en,
    output logic             psum_clr,
    output logic             psum_valid,
    input  logic             psum_pop
`ifdef PE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int unsigned CNT_W = $clog2(CREDITS + 1);

    pe_seq_cfg_t      cfg_q;
    logic [ROW_W-1:0] row_q;
    logic             beat_q;
    logic [ROW_W-1:0] rows_cfg;
    logic             last_beat;
    logic             last_row;
    logic [CNT_W-1:0] credits;
    logic             has_credit;

    assign rows_cfg  = ROW_W'(cfg_q.out_rows);
    // 4-bit mode splits each pass into two feature-map beats.
    assign last_beat = !cfg_q.bit_mode || beat_q;
    assign last_row  = (row_q == rows_cfg - 1'b1);

    assign busy       = (state != IDLE);
    assign fm_ready   = is_pass_state(state);
    assign mac_en     = fm_valid & fm_ready;
    assign psum_valid = (state == SIX) & has_credit;

    pe_psum_credit #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (psum_valid),
        .pop        (psum_pop),
        .credits    (credits),
        .has_credit (has_credit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wt_mode  <= A_MODE;
            done     <= 1'b0;
            psum_clr <= 1'b0;
            cfg_q    <= '0;
            row_q    <= '0;
            beat_q   <= 1'b0;
        end else begin
            done     <= 1'b0;
            psum_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_q.kernel_mode <= kernel_mode;
                        cfg_q.bit_mode    <= bit_mode;
                        cfg_q.out_rows    <= PE_SEQ_ROW_W'(out_rows);
                        row_q             <= '0;
                        beat_q            <= 1'b0;
                        state             <= ONE;
                    end
                end
                ONE: begin
                    if (rows_cfg == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state    <= TWO;
                        psum_clr <= 1'b1;
                        wt_mode  <= pass_wt_mode(TWO, cfg_q.kernel_mode);
                    end
                end
                TWO, THREE, FOUR, FIVE: begin
                    if (mac_en) begin
                        if (last_beat) begin
                            beat_q <= 1'b0;
                            if (is_last_pass(state, cfg_q.kernel_mode)) begin
                                state <= SIX;
                            end else begin
                                state   <= next_pass_state(state);
                                wt_mode <= pass_wt_mode(next_pass_state(state),
                                                        cfg_q.kernel_mode);
                            end
                        end else begin
                            beat_q <= 1'b1;
                        end
                    end
                end
                SIX: begin
                    // Without a credit the row result waits here for a pop.
                    if (psum_valid) begin
                        if (last_row) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            row_q    <= row_q + 1'b1;
                            state    <= TWO;
                            psum_clr <= 1'b1;
                            wt_mode  <= pass_wt_mode(TWO, cfg_q.kernel_mode);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PE_SEQ_PERF_CNT_EN
    logic stall_now;

    assign stall_now = (fm_ready & ~fm_valid) | ((state == SIX) & ~has_credit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cycles <= '0;
        end else if (stall_now && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule
